// File: rtl/obf_seqctl_pkg.sv
// Shared definitions for the obfuscated-sequence controller: default sequence
// index width and the controller state encoding.
package obf_seqctl_pkg;

    // Default width of the substitution index; a sequence holds at most 2**width words.
    localparam int OBF_PPC_WIDTH = 3;

    // IDLE waits for a reference instruction, RUN walks the generator's index.
    typedef enum logic {
        OBF_SEQ_IDLE = 1'b0,
        OBF_SEQ_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/obf_seqctl_if.sv
// Bundle of the fetch, generator and decode channels around obf_seqctl.
// The master modport is the controller's view, the slave modport is the
// surrounding pipeline and generator.
interface obf_seqctl_if
    import obf_seqctl_pkg::*;
#(
    parameter int PPC_W = OBF_PPC_WIDTH
);
    logic [31:0]      if_insn;
    logic             if_valid;
    logic             if_ready;

    logic [31:0]      gen_ref;
    logic [PPC_W-1:0] gen_ppc;
    logic [31:0]      gen_insn;
    logic             gen_last;
    logic             gen_skip;

    logic [31:0]      id_insn;
    logic             id_valid;
    logic             id_ready;
    logic [PPC_W-1:0] id_ppc;
    logic             id_last;
    logic             id_skip;

    modport master (
        input  if_insn, if_valid, gen_insn, gen_last, gen_skip, id_ready,
        output if_ready, gen_ref, gen_ppc, id_insn, id_valid, id_ppc, id_last, id_skip
    );

    modport slave (
        output if_insn, if_valid, gen_insn, gen_last, gen_skip, id_ready,
        input  if_ready, gen_ref, gen_ppc, id_insn, id_valid, id_ppc, id_last, id_skip
    );
endinterface

// File: rtl/obf_seqctl_slot.sv
// One-entry valid/ready output register carrying an obfuscated word and its
// sequence index, last and skip flags toward decode.
module obf_seqctl_slot
    import obf_seqctl_pkg::*;
#(
    parameter int PPC_W = OBF_PPC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             ready_i,
    input  logic [31:0]      insn_i,
    input  logic [PPC_W-1:0] ppc_i,
    input  logic             last_i,
    input  logic             skip_i,
    output logic             valid_o,
    output logic [31:0]      insn_o,
    output logic [PPC_W-1:0] ppc_o,
    output logic             last_o,
    output logic             skip_o
);

    logic             valid_q, valid_d;
    logic [31:0]      insn_q, insn_d;
    logic [PPC_W-1:0] ppc_q, ppc_d;
    logic             last_q, last_d;
    logic             skip_q, skip_d;

    // Clear wins, then a new word, then a consumed word empties the slot; payload only moves on load.
    always_comb begin
        valid_d = valid_q;
        insn_d  = insn_q;
        ppc_d   = ppc_q;
        last_d  = last_q;
        skip_d  = skip_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            insn_d  = insn_i;
            ppc_d   = ppc_i;
            last_d  = last_i;
            skip_d  = skip_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers, cleared to an empty all-zero entry on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            insn_q  <= 32'h0;
            ppc_q   <= '0;
            last_q  <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
            ppc_q   <= ppc_d;
            last_q  <= last_d;
            skip_q  <= skip_d;
        end
    end

    assign valid_o = valid_q;
    assign insn_o  = insn_q;
    assign ppc_o   = ppc_q;
    assign last_o  = last_q;
    assign skip_o  = skip_q;

endmodule

// File: rtl/obf_seqctl.sv
// Obfuscated-sequence controller between fetch and decode. Captures one
// reference instruction, steps the generator's substitution index until the
// generator flags the last word (or the index runs out), and forwards each
// word through a registered output slot.
// Optional feature macro: OBF_SEQCTL_BYPASS_EN adds bypass_i, which sends an
// instruction straight to the slot without running the generator.
module obf_seqctl
    import obf_seqctl_pkg::*;
#(
    parameter int PPC_W = OBF_PPC_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    obf_seqctl_if.master      bus,
    input  logic              flush_i,
`ifdef OBF_SEQCTL_BYPASS_EN
    input  logic              bypass_i,
`endif
    output logic              err_o
);

    seq_state_e       state_q, state_d;
    logic [31:0]      gen_ref_q, gen_ref_d;
    logic [PPC_W-1:0] gen_ppc_q, gen_ppc_d;
    logic             err_q, err_d;

    logic             slot_valid;
    logic             slot_free;
    logic             if_ready;
    logic             accept;
    logic             byp_accept;
    logic             seq_accept;
    logic             seq_load;
    logic             slot_load;
    logic             ovf;
    logic             seq_done;
    logic [31:0]      slot_insn;
    logic [PPC_W-1:0] slot_ppc;
    logic             slot_last;
    logic             slot_skip;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OBF_SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush aborts any sequence; RUN ends once the final word is loaded.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = OBF_SEQ_IDLE;
        end else begin
            case (state_q)
                OBF_SEQ_IDLE: if (seq_accept)          state_d = OBF_SEQ_RUN;
                OBF_SEQ_RUN:  if (seq_load && seq_done) state_d = OBF_SEQ_IDLE;
                default:                               state_d = OBF_SEQ_IDLE;
            endcase
        end
    end

    // Handshake decode: fetch acceptance, slot loading and the overflowing-index condition.
    always_comb begin
        slot_free = ~slot_valid | bus.id_ready;
`ifdef OBF_SEQCTL_BYPASS_EN
        if_ready   = (state_q == OBF_SEQ_IDLE) & ~flush_i & (~bypass_i | slot_free);
        accept     = if_ready & bus.if_valid;
        byp_accept = accept & bypass_i;
`else
        if_ready   = (state_q == OBF_SEQ_IDLE) & ~flush_i;
        accept     = if_ready & bus.if_valid;
        byp_accept = 1'b0;
`endif
        seq_accept = accept & ~byp_accept;
        seq_load   = (state_q == OBF_SEQ_RUN) & ~flush_i & slot_free;
        slot_load  = seq_load | byp_accept;
        ovf        = (gen_ppc_q == {PPC_W{1'b1}}) & ~bus.gen_last;
        seq_done   = bus.gen_last | ovf;
        if (byp_accept) begin
            slot_insn = bus.if_insn;
            slot_ppc  = '0;
            slot_last = 1'b1;
            slot_skip = 1'b0;
        end else begin
            slot_insn = bus.gen_insn;
            slot_ppc  = gen_ppc_q;
            slot_last = seq_done;
            slot_skip = bus.gen_skip;
        end
    end

    // Reference capture, index stepping on each loaded word, and sticky overflow flag.
    always_comb begin
        gen_ref_d = gen_ref_q;
        gen_ppc_d = gen_ppc_q;
        err_d     = err_q;
        if (flush_i) begin
            gen_ppc_d = '0;
        end else if (seq_accept) begin
            gen_ref_d = bus.if_insn;
            gen_ppc_d = '0;
        end else if (seq_load) begin
            gen_ppc_d = seq_done ? '0 : gen_ppc_q + PPC_W'(1);
            if (ovf) begin
                err_d = 1'b1;
            end
        end
    end

    // Generator-facing registers and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_ref_q <= 32'h0;
            gen_ppc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            gen_ref_q <= gen_ref_d;
            gen_ppc_q <= gen_ppc_d;
            err_q     <= err_d;
        end
    end

    obf_seqctl_slot #(
        .PPC_W   (PPC_W)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush_i),
        .load_i  (slot_load),
        .ready_i (bus.id_ready),
        .insn_i  (slot_insn),
        .ppc_i   (slot_ppc),
        .last_i  (slot_last),
        .skip_i  (slot_skip),
        .valid_o (slot_valid),
        .insn_o  (bus.id_insn),
        .ppc_o   (bus.id_ppc),
        .last_o  (bus.id_last),
        .skip_o  (bus.id_skip)
    );

    assign bus.id_valid = slot_valid;
    assign bus.if_ready = if_ready;
    assign bus.gen_ref  = gen_ref_q;
    assign bus.gen_ppc  = gen_ppc_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_obf_seqctl.sv
// Self-checking bench for obf_seqctl with a 3-bit sequence index. A toy
// combinational generator encodes sequence length in ref[3:0] (0 = never last)
// and the skip mask in ref[15:8]. A queue-based model predicts every output.
module tb_obf_seqctl;

    localparam int PPC_W = 3;
    localparam int MAXW  = 1 << PPC_W;

    typedef struct {
        logic [31:0] insn;
        int          ppc;
        logic        last;
        logic        skip;
        logic        ovf;
    } word_t;

    logic clk;
    logic rst_n;
    logic flush_i;
    logic bypass_i;
    logic err_o;

    int n_checks;
    int n_errors;
    int n_consumed;

    // Model state: words still to be produced, the output slot, and generator-side registers.
    word_t       seq[$];
    int          pending;
    logic        m_valid;
    word_t       m_slot;
    int          m_gen_ppc;
    logic [31:0] m_ref;
    logic        m_err;

    obf_seqctl_if #(.PPC_W(PPC_W)) bus ();

    obf_seqctl #(
        .PPC_W    (PPC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush_i  (flush_i),
`ifdef OBF_SEQCTL_BYPASS_EN
        .bypass_i (bypass_i),
`endif
        .err_o    (err_o)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy generator: word = ref ^ (A5000000 + index), last at index len-1, skip from mask bit.
    always_comb begin
        bus.gen_insn = bus.gen_ref ^ (32'hA500_0000 + 32'(bus.gen_ppc));
        bus.gen_last = (bus.gen_ref[3:0] != 4'd0) && ({1'b0, bus.gen_ppc} == bus.gen_ref[3:0] - 4'd1);
        bus.gen_skip = bus.gen_ref[8 + 32'(bus.gen_ppc)];
    end

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle's inputs just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] insn, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        bus.if_valid = v;
        bus.if_insn  = insn;
        bus.id_ready = rdy;
        flush_i      = fl;
    endtask

    // Expands one reference instruction into the full list of words decode should see.
    function automatic void build_seq(input logic [31:0] r);
        int    len;
        word_t w;
        logic  gen_end;
        len = int'(r[3:0]);
        for (int p = 0; p < MAXW; p++) begin
            gen_end = (len != 0) && (p == len - 1);
            w.insn  = r ^ (32'hA500_0000 + 32'(p));
            w.ppc   = p;
            w.ovf   = (p == MAXW - 1) && !gen_end;
            w.last  = gen_end || w.ovf;
            w.skip  = r[8 + p];
            seq.push_back(w);
            if (w.last) break;
        end
    endfunction

    // Every-cycle compare against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        logic slot_free;
        logic byp;
        logic exp_if_ready;
        if (!rst_n) begin
            seq.delete();
            pending   = 0;
            m_valid   = 1'b0;
            m_gen_ppc = 0;
            m_ref     = 32'h0;
            m_err     = 1'b0;
            checkOutput("rst_id_valid", 32'(bus.id_valid), 32'h0);
            checkOutput("rst_err", 32'(err_o), 32'h0);
        end else begin
`ifdef OBF_SEQCTL_BYPASS_EN
            byp = bypass_i;
`else
            byp = 1'b0;
`endif
            slot_free    = !m_valid || bus.id_ready;
            exp_if_ready = (pending == 0) && !flush_i && (!byp || slot_free);
            checkOutput("if_ready", 32'(bus.if_ready), 32'(exp_if_ready));
            checkOutput("id_valid", 32'(bus.id_valid), 32'(m_valid));
            checkOutput("err_o", 32'(err_o), 32'(m_err));
            checkOutput("gen_ref", bus.gen_ref, m_ref);
            checkOutput("gen_ppc", 32'(bus.gen_ppc), 32'(m_gen_ppc));
            if (m_valid) begin
                checkOutput("id_insn", bus.id_insn, m_slot.insn);
                checkOutput("id_ppc", 32'(bus.id_ppc), 32'(m_slot.ppc));
                checkOutput("id_last", 32'(bus.id_last), 32'(m_slot.last));
                checkOutput("id_skip", 32'(bus.id_skip), 32'(m_slot.skip));
                if (bus.id_ready) n_consumed++;
            end
            if (flush_i) begin
                m_valid   = 1'b0;
                pending   = 0;
                m_gen_ppc = 0;
                seq.delete();
            end else if (pending > 0) begin
                if (slot_free) begin
                    m_slot  = seq.pop_front();
                    m_valid = 1'b1;
                    pending--;
                    m_gen_ppc = (pending > 0) ? m_gen_ppc + 1 : 0;
                    if (m_slot.ovf) m_err = 1'b1;
                end
            end else if (exp_if_ready && bus.if_valid && byp) begin
                m_slot.insn = bus.if_insn;
                m_slot.ppc  = 0;
                m_slot.last = 1'b1;
                m_slot.skip = 1'b0;
                m_valid     = 1'b1;
            end else begin
                if (bus.id_ready) m_valid = 1'b0;
                if (exp_if_ready && bus.if_valid) begin
                    build_seq(bus.if_insn);
                    pending   = seq.size();
                    m_ref     = bus.if_insn;
                    m_gen_ppc = 0;
                end
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int base;
        n_checks     = 0;
        n_errors     = 0;
        n_consumed   = 0;
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        bypass_i     = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_insn  = 32'h0;
        bus.id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values.
        @(negedge clk);
        checkOutput("reset_id_valid", 32'(bus.id_valid), 32'h0);
        checkOutput("reset_id_insn", bus.id_insn, 32'h0);
        checkOutput("reset_gen_ref", bus.gen_ref, 32'h0);
        checkOutput("reset_gen_ppc", 32'(bus.gen_ppc), 32'h0);
        checkOutput("reset_err", 32'(err_o), 32'h0);
        checkOutput("reset_if_ready", 32'(bus.if_ready), 32'h1);

        // Three-word sequence, skip on index 1, decode always ready.
        applyStimulus(1'b1, 32'h0000_0203, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_accept_ready", 32'(bus.if_ready), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_gen_ref", bus.gen_ref, 32'h0000_0203);
        checkOutput("t1_busy", 32'(bus.if_ready), 32'h0);
        checkOutput("t1_not_yet", 32'(bus.id_valid), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_w0_ppc", 32'(bus.id_ppc), 32'h0);
        checkOutput("t1_w0_insn", bus.id_insn, 32'hA500_0203);
        checkOutput("t1_w0_last", 32'(bus.id_last), 32'h0);
        checkOutput("t1_w0_skip", 32'(bus.id_skip), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_w1_ppc", 32'(bus.id_ppc), 32'h1);
        checkOutput("t1_w1_insn", bus.id_insn, 32'hA500_0202);
        checkOutput("t1_w1_skip", 32'(bus.id_skip), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_w2_ppc", 32'(bus.id_ppc), 32'h2);
        checkOutput("t1_w2_insn", bus.id_insn, 32'hA500_0201);
        checkOutput("t1_w2_last", 32'(bus.id_last), 32'h1);
        checkOutput("t1_w2_if_ready", 32'(bus.if_ready), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_drained", 32'(bus.id_valid), 32'h0);

        // Backpressure on the first word of a four-word sequence.
        base = n_consumed;
        applyStimulus(1'b1, 32'h0000_0004, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("t2_stall_ppc", 32'(bus.id_ppc), 32'h0);
            checkOutput("t2_stall_insn", bus.id_insn, 32'hA500_0004);
            checkOutput("t2_stall_gen_ppc", 32'(bus.gen_ppc), 32'h1);
        end
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t2_words_seen", 32'(n_consumed - base), 32'd4);
        checkOutput("t2_model_empty", 32'(seq.size()), 32'h0);

        // Index overflow: generator never flags last.
        applyStimulus(1'b1, 32'h0000_00A0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int p = 0; p < MAXW; p++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("t3_ppc", 32'(bus.id_ppc), 32'(p));
            checkOutput("t3_last", 32'(bus.id_last), 32'(p == MAXW - 1));
        end
        checkOutput("t3_err", 32'(err_o), 32'h1);
        checkOutput("t3_if_ready", 32'(bus.if_ready), 32'h1);
        applyStimulus(1'b1, 32'h0000_0102, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_next_insn", bus.id_insn, 32'hA500_0102);
        checkOutput("t3_next_skip", 32'(bus.id_skip), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_next_last", 32'(bus.id_last), 32'h1);
        checkOutput("t3_err_sticky", 32'(err_o), 32'h1);

        // Flush while word 1 of a four-word sequence is on the output.
        applyStimulus(1'b1, 32'h0000_0004, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0403, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t4_flush_ppc", 32'(bus.id_ppc), 32'h1);
        checkOutput("t4_flush_no_accept", 32'(bus.if_ready), 32'h0);
        applyStimulus(1'b1, 32'h0000_0403, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t4_after_valid", 32'(bus.id_valid), 32'h0);
        checkOutput("t4_after_ready", 32'(bus.if_ready), 32'h1);
        checkOutput("t4_after_gen_ppc", 32'(bus.gen_ppc), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t4_restart_ppc", 32'(bus.id_ppc), 32'h0);
        checkOutput("t4_restart_insn", bus.id_insn, 32'hA500_0403);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0001, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t4_idle_flush_ref", bus.gen_ref, 32'h0000_0403);

        // Asynchronous reset in the middle of a sequence.
        applyStimulus(1'b1, 32'h0000_0005, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_gen_ppc", 32'(bus.gen_ppc), 32'h0);
        checkOutput("t5_rst_gen_ref", bus.gen_ref, 32'h0);
        checkOutput("t5_rst_err", 32'(err_o), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_post_ready", 32'(bus.if_ready), 32'h1);
        checkOutput("t5_post_valid", 32'(bus.id_valid), 32'h0);

`ifdef OBF_SEQCTL_BYPASS_EN
        // Bypass straight into the output slot.
        applyStimulus(1'b1, 32'h1500_0000, 1'b1, 1'b0);
        bypass_i = 1'b1;
        @(negedge clk);
        checkOutput("t6_accept", 32'(bus.if_ready), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        bypass_i = 1'b0;
        @(negedge clk);
        checkOutput("t6_valid", 32'(bus.id_valid), 32'h1);
        checkOutput("t6_insn", bus.id_insn, 32'h1500_0000);
        checkOutput("t6_last", 32'(bus.id_last), 32'h1);
        checkOutput("t6_ppc", 32'(bus.id_ppc), 32'h0);
        checkOutput("t6_gen_ref", bus.gen_ref, 32'h0);
`endif

        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
